// File: rtl/driver_pkg.sv
// Shared definitions for the passive-arming controller: state encoding and
// default timing parameters.
package driver_pkg;

  typedef enum logic [1:0] {
    DISARMED  = 2'd0,
    DOOR_OPEN = 2'd1,
    COUNTING  = 2'd2,
    ARMED     = 2'd3
  } state_t;

  localparam int ARM_DELAY_DEF = 10;
  localparam int CNT_W_DEF     = 4;

endpackage

// File: rtl/driver_arm_timer.sv
// Arming delay counter: counts enabled cycles, saturates at ARM_DELAY-1 and
// flags done while enabled at that terminal value.
module arm_timer
  import driver_pkg::*;
#(
  parameter int ARM_DELAY = ARM_DELAY_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(ARM_DELAY - 1);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != LAST)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign done = enable && (count_reg == LAST);

endmodule

// File: rtl/driver.sv
// Passive-arming FSM: arms the alarm a fixed delay after the driver door is
// opened and closed with ignition off; ignition on disarms at once.
module driver
  import driver_pkg::*;
#(
  parameter int ARM_DELAY = ARM_DELAY_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic door,
  input  logic ignicao,
  output logic armar
);

  state_t state_reg, state_next;
  logic   armar_reg;
  logic   timer_enable, timer_clear, timer_done;

  arm_timer #(
    .ARM_DELAY (ARM_DELAY),
    .CNT_W     (CNT_W)
  ) u_arm_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (timer_enable),
    .done   (timer_done)
  );

  // Ignition is tested first in every state so it always beats the door.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      DISARMED: begin
        if (!ignicao && door) state_next = DOOR_OPEN;
      end
      DOOR_OPEN: begin
        if (ignicao)    state_next = DISARMED;
        else if (!door) state_next = COUNTING;
      end
      COUNTING: begin
        if (ignicao)         state_next = DISARMED;
        else if (door)       state_next = DOOR_OPEN;
        else if (timer_done) state_next = ARMED;
      end
      ARMED: begin
        if (ignicao) state_next = DISARMED;
      end
      default: state_next = DISARMED;
    endcase
  end

  // The counter only runs while counting and is zeroed whenever we are not
  // going to be counting next, so every entry starts from zero.
  assign timer_enable = (state_reg == COUNTING);
  assign timer_clear  = (state_next != COUNTING);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= DISARMED;
      armar_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      armar_reg <= (state_next == ARMED);
    end
  end

  assign armar = armar_reg;

endmodule

// File: tb/tb_driver.sv
// Directed bench for the passive-arming controller: per-cycle vector table
// plus a hand-timed latency measurement.
module tb_driver;

  logic clock = 1'b0;
  logic reset, door, ignicao;
  logic armar;

  int checks = 0;
  int errors = 0;

  driver dut (
    .clock   (clock),
    .reset   (reset),
    .door    (door),
    .ignicao (ignicao),
    .armar   (armar)
  );

  always #5 clock = ~clock;

  // Each record holds inputs for n consecutive edges and the armar value
  // expected after every one of those edges.
  typedef struct {
    logic rst;
    logic dr;
    logic ign;
    int   n;
    logic exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic d, input logic i,
                     input int n, input logic e);
    vec_t v;
    v.rst = r; v.dr = d; v.ign = i; v.n = n; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic step(input logic r, input logic d, input logic i);
    reset = r; door = d; ignicao = i;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: armar=%0b expected %0b", name, act, exp);
    end
  endtask

  int cycles;

  initial begin
    reset = 1'b1; door = 1'b0; ignicao = 1'b0;

    // reset
    add(1, 0, 0, 1, 0);
    // nominal arm: 10 edges after door closes, door ignored once armed
    add(0, 1, 0, 1, 0);
    add(0, 0, 0, 10, 0);
    add(0, 0, 0, 2, 1);
    add(0, 1, 0, 3, 1);
    // ignition in ARMED disarms on next edge; stays disarmed afterwards
    add(0, 0, 1, 1, 0);
    add(0, 0, 0, 5, 0);
    // door reopened at count=5 restarts the full delay
    add(0, 1, 0, 1, 0);
    add(0, 0, 0, 6, 0);
    add(0, 1, 0, 1, 0);
    add(0, 0, 0, 10, 0);
    add(0, 0, 0, 1, 1);
    // disarm, then ignition while counting: door=0 alone must not arm
    add(0, 0, 1, 1, 0);
    add(0, 1, 0, 1, 0);
    add(0, 0, 0, 4, 0);
    add(0, 0, 1, 1, 0);
    add(0, 0, 0, 15, 0);
    // door and ignition together from reset: never leaves DISARMED
    add(1, 1, 1, 1, 0);
    add(0, 1, 1, 50, 0);
    add(0, 0, 0, 12, 0);
    // arm, then reset while ARMED; re-arm needs a fresh open/close
    add(0, 1, 0, 1, 0);
    add(0, 0, 0, 10, 0);
    add(0, 0, 0, 1, 1);
    add(1, 0, 0, 1, 0);
    add(0, 0, 0, 15, 0);
    add(0, 1, 0, 1, 0);
    add(0, 0, 0, 10, 0);
    add(0, 0, 0, 1, 1);
    // door and ignition together while ARMED: ignition wins
    add(0, 1, 1, 1, 0);
    add(0, 0, 0, 12, 0);

    for (int v = 0; v < vecs.size(); v++) begin
      for (int c = 0; c < vecs[v].n; c++) begin
        step(vecs[v].rst, vecs[v].dr, vecs[v].ign);
        check($sformatf("vec%0d_cyc%0d", v, c), armar, vecs[v].exp);
      end
    end

    // Latency: count edges from the edge sampling door=0 to armar rising.
    step(1, 0, 0);
    step(0, 1, 0);
    cycles = 0;
    door = 1'b0;
    while (armar !== 1'b1 && cycles < 30) begin
      step(0, 0, 0);
      cycles++;
    end
    checks++;
    if (cycles != 11) begin
      errors++;
      $display("FAIL latency: armar rose after %0d edges, expected 11 (door-close edge + 10)",
               cycles);
    end

    // Reset mid-count: armar stays low and the count does not survive.
    step(0, 0, 1);
    step(0, 1, 0);
    for (int c = 0; c < 5; c++) step(0, 0, 0);
    step(1, 0, 0);
    check("reset_midcount", armar, 1'b0);
    for (int c = 0; c < 10; c++) step(0, 0, 0);
    check("no_arm_after_midcount_reset", armar, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
